// File: rtl/fpfx_pkg.sv
// fpfx_pkg: shared constants and stage payload types for the float/fixed
// conversion pipeline (fp_fixed_convert_pipe).
//   - IEEE-754 single-precision field constants
//   - flag bit positions within flags[2:0] = {invalid, overflow, inexact}
//   - mode encodings for the n input
//   - stage payload structs carried between pipeline registers
package fpfx_pkg;

    localparam int EXP_BIAS = 127;
    localparam int MANT_W   = 23;
    localparam int EXP_W    = 8;

    localparam int FLG_INVALID  = 2;
    localparam int FLG_OVERFLOW = 1;
    localparam int FLG_INEXACT  = 0;

    localparam logic MODE_F2X = 1'b0;
    localparam logic MODE_X2F = 1'b1;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    // S1 payload.
    // f2x: exp = biased exponent, mant = {hidden, fraction}.
    // x2f: exp = leading-one index p, mant = |x| (WL+1 significant bits).
    typedef struct packed {
        logic             mode;
        logic             sign;
        logic signed [10:0] exp;
        logic [31:0]      mant;
        fp_class_e        cls;
    } stage_t;

    // S2 payload.
    // f2x: mag = fixed-point magnitude after shift, sticky = discarded bits.
    // x2f: fexp/fmant = packed float fields, sticky = dropped mantissa bits.
    typedef struct packed {
        logic              mode;
        logic              sign;
        fp_class_e         cls;
        logic [63:0]       mag;
        logic              sticky;
        logic [EXP_W-1:0]  fexp;
        logic [MANT_W-1:0] fmant;
    } shift_t;

endpackage

// File: rtl/lzd_param.sv
// lzd_param: parametrised leading-one detector (combinational).
//   vec   : input vector, WIDTH bits
//   index : position of the most significant set bit (0 when none)
//   valid : 1 when any bit of vec is set
module lzd_param #(
    parameter int WIDTH = 32,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    // Scan upward so the highest set bit is the last one written.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                index = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_fixed_convert_pipe.sv
// fp_fixed_convert_pipe: pipelined IEEE-754 single <-> signed Q(INT_W).(FRAC_W)
// converter, one conversion per enabled cycle.
//   clk, reset_n : clock, synchronous active-low reset (overrides clk_en)
//   clk_en       : stage enable; low freezes every register including outputs
//   start        : input valid, sampled when clk_en=1
//   n            : mode, 0 = float->fixed, 1 = fixed->float (travels with data)
//   dataa        : float bits, or fixed word in dataa[WL-1:0]
//   result       : sign-extended fixed word, or float bits
//   done         : one-cycle pulse per accepted start, 3 enabled edges after
//                  the edge that captured start
//   flags        : {invalid, overflow, inexact}, aligned with done
module fp_fixed_convert_pipe
    import fpfx_pkg::*;
#(
    parameter int INT_W  = 8,
    parameter int FRAC_W = 13
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic        n,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic [2:0]  flags
);

    localparam int WL    = INT_W + FRAC_W;
    localparam int IDX_W = $clog2(WL + 1);

    localparam logic [63:0] MAG_LIM = 64'd1 << (WL - 1);
    localparam logic [31:0] SAT_POS = 32'(MAG_LIM - 64'd1);
    localparam logic [31:0] SAT_NEG = ~SAT_POS;

    // Input capture rank
    logic        v0;
    logic        in_mode;
    logic [31:0] in_data;

    logic   v1, v2;
    stage_t s1, s1_next;
    shift_t s2, s2_next;

    logic [31:0] res_next;
    logic [2:0]  flg_next;

    // ---------------- S1: unpack, classify, leading-one detect ----------------
    logic [EXP_W-1:0]  f_exp;
    logic [MANT_W-1:0] f_frac;
    logic [WL-1:0]     x_word;
    logic [WL:0]       x_ext;
    logic [WL:0]       x_mag;
    logic [IDX_W-1:0]  lz_idx;
    logic              lz_valid;

    always_comb begin
        f_exp  = in_data[30:23];
        f_frac = in_data[22:0];
        x_word = in_data[WL-1:0];
        // One extra bit so |most negative| is representable.
        x_ext  = {x_word[WL-1], x_word};
        x_mag  = x_word[WL-1] ? (~x_ext + (WL+1)'(1)) : x_ext;
    end

    lzd_param #(.WIDTH(WL + 1)) u_lzd (
        .vec   (x_mag),
        .index (lz_idx),
        .valid (lz_valid)
    );

    always_comb begin
        s1_next      = '0;
        s1_next.mode = in_mode;
        if (in_mode == MODE_F2X) begin
            s1_next.sign = in_data[31];
            s1_next.exp  = 11'(f_exp);
            s1_next.mant = {8'b0, (f_exp != '0), f_frac};
            if (f_exp == '1)
                s1_next.cls = (f_frac != '0) ? CLS_NAN : CLS_INF;
            else if (f_exp == '0)
                s1_next.cls = (f_frac != '0) ? CLS_DENORM : CLS_ZERO;
            else
                s1_next.cls = CLS_NORM;
        end else begin
            s1_next.sign = x_word[WL-1];
            s1_next.exp  = 11'(lz_idx);
            s1_next.mant = 32'(x_mag);
            s1_next.cls  = lz_valid ? CLS_NORM : CLS_ZERO;
        end
    end

    // ---------------- S2: barrel shift and sticky ----------------
    int          sh;
    logic [5:0]  amt;
    logic [31:0] norm;

    always_comb begin
        s2_next      = '0;
        s2_next.mode = s1.mode;
        s2_next.sign = s1.sign;
        s2_next.cls  = s1.cls;
        // Fixed magnitude = mant * 2^(e - bias - 23 + FRAC_W)
        sh   = int'(s1.exp) - (EXP_BIAS + MANT_W) + FRAC_W;
        amt  = '0;
        norm = '0;
        if (s1.mode == MODE_F2X) begin
            case (s1.cls)
                CLS_NORM: begin
                    if (sh >= 32) begin
                        // Far out of range: force a magnitude that saturates.
                        s2_next.mag = '1;
                    end else if (sh >= 0) begin
                        amt         = 6'(sh);
                        s2_next.mag = {32'b0, s1.mant} << amt;
                    end else if (sh <= -32) begin
                        s2_next.sticky = |s1.mant;
                    end else begin
                        amt            = 6'(-sh);
                        s2_next.mag    = {32'b0, s1.mant} >> amt;
                        s2_next.sticky = |(s1.mant & ((32'h1 << amt) - 32'h1));
                    end
                end
                CLS_DENORM: s2_next.sticky = |s1.mant[MANT_W-1:0];
                default: ;
            endcase
        end else begin
            // Shift by 32-p pushes the leading one out, leaving the bits
            // below it left-aligned at bit 31.
            amt            = 6'(32 - int'(s1.exp));
            norm           = s1.mant << amt;
            s2_next.fexp   = EXP_W'(EXP_BIAS + int'(s1.exp) - FRAC_W);
            s2_next.fmant  = norm[31:9];
            s2_next.sticky = |norm[8:0];
        end
    end

    // ---------------- S3: saturate and pack ----------------
    logic [WL-1:0] word;

    always_comb begin
        res_next = '0;
        flg_next = '0;
        word     = '0;
        if (s2.mode == MODE_F2X) begin
            case (s2.cls)
                CLS_NAN: flg_next[FLG_INVALID] = 1'b1;
                CLS_INF: begin
                    res_next               = s2.sign ? SAT_NEG : SAT_POS;
                    flg_next[FLG_OVERFLOW] = 1'b1;
                end
                CLS_NORM: begin
                    // -2^(INT_W-1) is representable, +2^(INT_W-1) is not.
                    if (s2.sign ? (s2.mag > MAG_LIM) : (s2.mag >= MAG_LIM)) begin
                        res_next               = s2.sign ? SAT_NEG : SAT_POS;
                        flg_next[FLG_OVERFLOW] = 1'b1;
                    end else begin
                        word = s2.sign ? (~s2.mag[WL-1:0] + WL'(1)) : s2.mag[WL-1:0];
                        res_next              = 32'($signed(word));
                        flg_next[FLG_INEXACT] = s2.sticky;
                    end
                end
                default: flg_next[FLG_INEXACT] = s2.sticky;
            endcase
        end else if (s2.cls != CLS_ZERO) begin
            res_next              = {s2.sign, s2.fexp, s2.fmant};
            flg_next[FLG_INEXACT] = s2.sticky;
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v0     <= 1'b0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else if (clk_en) begin
            v0 <= start;
            if (start) begin
                in_mode <= n;
                in_data <= dataa;
            end
            v1 <= v0;
            if (v0) s1 <= s1_next;
            v2 <= v1;
            if (v1) s2 <= s2_next;
            done <= v2;
            if (v2) begin
                result <= res_next;
                flags  <= flg_next;
            end
        end
    end

endmodule

// File: tb/tb_fp_fixed_convert_pipe.sv
module tb_fp_fixed_convert_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic        start;
    logic        n;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done;
    logic [2:0]  flags;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_fixed_convert_pipe #(.INT_W(8), .FRAC_W(13)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .start   (start),
        .n       (n),
        .dataa   (dataa),
        .result  (result),
        .done    (done),
        .flags   (flags)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] r, input logic [2:0] f);
        chk({tag, ".done"}, {31'b0, done}, 32'd1);
        chk({tag, ".result"}, result, r);
        chk({tag, ".flags"}, {29'b0, flags}, {29'b0, f});
    endtask

    // Single operation with full latency check: start captured at edge k,
    // done visible only after edge k+3, and only for that one cycle.
    task automatic run_one(input string tag, input logic mode, input logic [31:0] d,
                           input logic [31:0] r, input logic [2:0] f);
        @(negedge clk);
        start = 1'b1; n = mode; dataa = d;
        @(negedge clk);
        start = 1'b0; dataa = '0;
        chk({tag, ".lat1"}, {31'b0, done}, 32'd0);
        @(negedge clk);
        chk({tag, ".lat2"}, {31'b0, done}, 32'd0);
        @(negedge clk);
        chk({tag, ".lat3"}, {31'b0, done}, 32'd0);
        @(negedge clk);
        chk_out(tag, r, f);
        @(negedge clk);
        chk({tag, ".pulse"}, {31'b0, done}, 32'd0);
        chk({tag, ".hold"}, result, r);
    endtask

    logic        bm[8];
    logic [31:0] bd[8];
    logic [31:0] br[8];
    logic [2:0]  bf[8];

    initial begin
        reset_n = 1'b0; clk_en = 1'b1; start = 1'b0; n = 1'b0; dataa = '0;
        repeat (2) @(negedge clk);
        chk("rst.done", {31'b0, done}, 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.flags", {29'b0, flags}, 32'd0);
        reset_n = 1'b1;

        // float -> fixed
        run_one("f2x_1p0",   1'b0, 32'h3F800000, 32'h00002000, 3'b000);
        run_one("f2x_m2p5",  1'b0, 32'hC0200000, 32'hFFFFB000, 3'b000);
        run_one("f2x_300",   1'b0, 32'h43960000, 32'h000FFFFF, 3'b010);
        run_one("f2x_m128",  1'b0, 32'hC3000000, 32'hFFF00000, 3'b000);
        run_one("f2x_p128",  1'b0, 32'h43000000, 32'h000FFFFF, 3'b010);
        run_one("f2x_max",   1'b0, 32'h42FFFFF0, 32'h000FFFFF, 3'b000);
        run_one("f2x_nan",   1'b0, 32'h7FC00000, 32'h00000000, 3'b100);
        run_one("f2x_ninf",  1'b0, 32'hFF800000, 32'hFFF00000, 3'b010);
        run_one("f2x_tiny",  1'b0, 32'h38800000, 32'h00000000, 3'b001);
        run_one("f2x_denrm", 1'b0, 32'h00000001, 32'h00000000, 3'b001);
        run_one("f2x_inex",  1'b0, 32'h3F800001, 32'h00002000, 3'b001);
        run_one("f2x_mhalf", 1'b0, 32'hBF000000, 32'hFFFFF000, 3'b000);

        // fixed -> float
        run_one("x2f_6",     1'b1, 32'h0000C000, 32'h40C00000, 3'b000);
        run_one("x2f_m128",  1'b1, 32'h00100000, 32'hC3000000, 3'b000);
        run_one("x2f_lsb",   1'b1, 32'h00000001, 32'h39000000, 3'b000);
        run_one("x2f_zero",  1'b1, 32'h00000000, 32'h00000000, 3'b000);
        run_one("x2f_upper", 1'b1, 32'hFFE0C000, 32'h40C00000, 3'b000);
        run_one("x2f_m1",    1'b1, 32'h001FFFFF, 32'hB9000000, 3'b000);
        run_one("x2f_max",   1'b1, 32'h000FFFFF, 32'h42FFFFF0, 3'b000);

        // Back-to-back, mode alternating every cycle
        bm[0] = 1'b0; bd[0] = 32'h3F800000; br[0] = 32'h00002000; bf[0] = 3'b000;
        bm[1] = 1'b1; bd[1] = 32'h0000C000; br[1] = 32'h40C00000; bf[1] = 3'b000;
        bm[2] = 1'b0; bd[2] = 32'hC0200000; br[2] = 32'hFFFFB000; bf[2] = 3'b000;
        bm[3] = 1'b1; bd[3] = 32'h00100000; br[3] = 32'hC3000000; bf[3] = 3'b000;
        bm[4] = 1'b0; bd[4] = 32'h43960000; br[4] = 32'h000FFFFF; bf[4] = 3'b010;
        bm[5] = 1'b1; bd[5] = 32'h00000001; br[5] = 32'h39000000; bf[5] = 3'b000;
        bm[6] = 1'b0; bd[6] = 32'h7FC00000; br[6] = 32'h00000000; bf[6] = 3'b100;
        bm[7] = 1'b1; bd[7] = 32'h00000000; br[7] = 32'h00000000; bf[7] = 3'b000;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c >= 4) chk_out($sformatf("b2b%0d", c - 4), br[c-4], bf[c-4]);
            else        chk($sformatf("b2b_idle%0d", c), {31'b0, done}, 32'd0);
            if (c < 8) begin
                start = 1'b1; n = bm[c]; dataa = bd[c];
            end else begin
                start = 1'b0; dataa = '0;
            end
        end
        @(negedge clk);
        chk("b2b_end", {31'b0, done}, 32'd0);

        // Freeze with the pipe full
        bm[0] = 1'b0; bd[0] = 32'h42FFFFF0; br[0] = 32'h000FFFFF; bf[0] = 3'b000;
        bm[1] = 1'b1; bd[1] = 32'h001FFFFF; br[1] = 32'hB9000000; bf[1] = 3'b000;
        bm[2] = 1'b0; bd[2] = 32'hFF800000; br[2] = 32'hFFF00000; bf[2] = 3'b010;
        bm[3] = 1'b1; bd[3] = 32'h000FFFFF; br[3] = 32'h42FFFFF0; bf[3] = 3'b000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            start = 1'b1; n = bm[c]; dataa = bd[c];
        end
        @(negedge clk);
        chk_out("frz_a", br[0], bf[0]);
        // A start during the freeze must not be captured.
        clk_en = 1'b0; start = 1'b1; n = 1'b0; dataa = 32'h3F800000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_out($sformatf("frz_hold%0d", c), br[0], bf[0]);
        end
        clk_en = 1'b1; start = 1'b0; dataa = '0;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            chk_out($sformatf("frz_rel%0d", c), br[c], bf[c]);
        end
        @(negedge clk);
        chk("frz_end1", {31'b0, done}, 32'd0);
        @(negedge clk);
        chk("frz_end2", {31'b0, done}, 32'd0);
        chk("frz_keep", result, 32'h42FFFFF0);

        // Reset with two operations in flight (clk_en low: reset still wins)
        @(negedge clk);
        start = 1'b1; n = 1'b0; dataa = 32'hC0200000;
        @(negedge clk);
        start = 1'b1; n = 1'b1; dataa = 32'h0000C000;
        @(negedge clk);
        start = 1'b0; dataa = '0; reset_n = 1'b0; clk_en = 1'b0;
        @(negedge clk);
        chk("mid_rst.done", {31'b0, done}, 32'd0);
        chk("mid_rst.result", result, 32'd0);
        chk("mid_rst.flags", {29'b0, flags}, 32'd0);
        reset_n = 1'b1; clk_en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("mid_rst_drop%0d", c), {31'b0, done}, 32'd0);
        end

        // Pipe still works after the mid-flight reset
        run_one("post_rst", 1'b0, 32'h3F800000, 32'h00002000, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
